// File: rtl/counter_peripheral.sv
// counter_peripheral
//   Bus-slave peripheral with two independent windows sharing one clock.
//   Register window: up/down counter with CONFIG, STATUS (sticky WRAP, W1C)
//   and a level interrupt. Memory window: MEM_DEPTH x 32-bit scratch RAM.
//   Reads on either window return registered data one cycle after the strobe,
//   qualified by a one-cycle valid pulse; data_out holds between reads.
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   reg_read        register read strobe
//   reg_write       register write strobe
//   reg_address     register word index (0 COUNT, 1 CONFIG, 2 STATUS, 3 rsvd)
//   reg_data_in     register write data
//   reg_read_valid  register read data valid pulse
//   reg_data_out    register read data
//   mem_read        RAM read strobe
//   mem_write       RAM write strobe
//   mem_address     RAM word index
//   mem_data_in     RAM write data
//   mem_read_valid  RAM read data valid pulse
//   mem_data_out    RAM read data
//   irq             level interrupt, WRAP & IE
module counter_peripheral #(
    parameter int CNT_WIDTH = 16,
    parameter int MEM_DEPTH = 256,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_read,
    input  logic          reg_write,
    input  logic [1:0]    reg_address,
    input  logic [31:0]   reg_data_in,
    output logic          reg_read_valid,
    output logic [31:0]   reg_data_out,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] mem_address,
    input  logic [31:0]   mem_data_in,
    output logic          mem_read_valid,
    output logic [31:0]   mem_data_out,
    output logic          irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Register window state
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 en_q, en_d;
    logic                 up_q, up_d;
    logic                 ie_q, ie_d;
    logic                 wrap_q, wrap_d;
    logic                 wrap_hit;
    logic [31:0]          reg_rdata_q, reg_rdata_d;
    logic                 reg_rvalid_q;

    // Memory window state
    logic [31:0]          mem_q [MEM_DEPTH];
    logic [31:0]          mem_rdata_q;
    logic                 mem_rvalid_q;

    logic count_wr, cfg_wr, status_wr;

    // Counter bits above CNT_WIDTH are write-ignored.
    logic unused_wdata;
    assign unused_wdata = ^reg_data_in[31:CNT_WIDTH];

    assign count_wr  = reg_write && (reg_address == 2'd0);
    assign cfg_wr    = reg_write && (reg_address == 2'd1);
    assign status_wr = reg_write && (reg_address == 2'd2);

    // Next-state for counter, config and sticky wrap flag.
    always_comb begin
        count_d  = count_q;
        wrap_hit = 1'b0;
        en_d     = en_q;
        up_d     = up_q;
        ie_d     = ie_q;
        wrap_d   = wrap_q;

        // A bus write to COUNT overrides counting in the same cycle.
        if (count_wr) begin
            count_d = reg_data_in[CNT_WIDTH-1:0];
        end else if (en_q) begin
            if (up_q) begin
                count_d  = count_q + CNT_ONE;
                wrap_hit = &count_q;
            end else begin
                count_d  = count_q - CNT_ONE;
                wrap_hit = ~|count_q;
            end
        end

        if (cfg_wr) begin
            en_d = reg_data_in[0];
            up_d = reg_data_in[1];
            ie_d = reg_data_in[2];
        end

        // Clear first, then set, so a coincident wrap keeps the flag.
        if (status_wr && reg_data_in[0]) begin
            wrap_d = 1'b0;
        end
        if (wrap_hit) begin
            wrap_d = 1'b1;
        end
    end

    // Read mux samples current register values, so a same-cycle write
    // is seen only by the following read.
    always_comb begin
        reg_rdata_d = reg_rdata_q;
        if (reg_read) begin
            case (reg_address)
                2'd0:    reg_rdata_d = {{(32-CNT_WIDTH){1'b0}}, count_q};
                2'd1:    reg_rdata_d = {29'd0, ie_q, up_q, en_q};
                2'd2:    reg_rdata_d = {31'd0, wrap_q};
                default: reg_rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            en_q         <= 1'b0;
            up_q         <= 1'b0;
            ie_q         <= 1'b0;
            wrap_q       <= 1'b0;
            reg_rdata_q  <= 32'd0;
            reg_rvalid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            en_q         <= en_d;
            up_q         <= up_d;
            ie_q         <= ie_d;
            wrap_q       <= wrap_d;
            reg_rdata_q  <= reg_rdata_d;
            reg_rvalid_q <= reg_read;
        end
    end

    // RAM array carries no reset.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem_q[mem_address] <= mem_data_in;
        end
    end

    // Read port returns the pre-write word on a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata_q  <= 32'd0;
            mem_rvalid_q <= 1'b0;
        end else begin
            mem_rvalid_q <= mem_read;
            if (mem_read) begin
                mem_rdata_q <= mem_q[mem_address];
            end
        end
    end

    assign reg_read_valid = reg_rvalid_q;
    assign reg_data_out   = reg_rdata_q;
    assign mem_read_valid = mem_rvalid_q;
    assign mem_data_out   = mem_rdata_q;
    assign irq            = wrap_q & ie_q;

endmodule

// File: tb/tb_counter_peripheral.sv
module tb_counter_peripheral;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_read, reg_write;
    logic [1:0]  reg_address;
    logic [31:0] reg_data_in;
    logic        reg_read_valid;
    logic [31:0] reg_data_out;
    logic        mem_read, mem_write;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_valid;
    logic [31:0] mem_data_out;
    logic        irq;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] reg_exp_q[$];
    logic [31:0] mem_exp_q[$];

    counter_peripheral dut (
        .clk            (clk),
        .reset          (reset),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_address    (reg_address),
        .reg_data_in    (reg_data_in),
        .reg_read_valid (reg_read_valid),
        .reg_data_out   (reg_data_out),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_valid (mem_read_valid),
        .mem_data_out   (mem_data_out),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every valid pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (reg_read_valid) begin
            if (reg_exp_q.size() == 0) chk("reg_extra_valid", 32'd1, 32'd0);
            else chk("reg_rdata", reg_data_out, reg_exp_q.pop_front());
        end
        if (mem_read_valid) begin
            if (mem_exp_q.size() == 0) chk("mem_extra_valid", 32'd1, 32'd0);
            else chk("mem_rdata", mem_data_out, mem_exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        reg_write = 1'b1; reg_address = a; reg_data_in = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, input logic [31:0] e);
        reg_read = 1'b1; reg_address = a;
        reg_exp_q.push_back(e);
        tick();
        chk("reg_valid", {31'd0, reg_read_valid}, 32'd1);
        reg_read = 1'b0;
    endtask

    task automatic reg_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
        reg_read = 1'b1; reg_write = 1'b1; reg_address = a; reg_data_in = d;
        reg_exp_q.push_back(e);
        tick();
        reg_read = 1'b0; reg_write = 1'b0;
    endtask

    task automatic mem_wr(input logic [7:0] a, input logic [31:0] d);
        mem_write = 1'b1; mem_address = a; mem_data_in = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic mem_rd(input logic [7:0] a, input logic [31:0] e);
        mem_read = 1'b1; mem_address = a;
        mem_exp_q.push_back(e);
        tick();
        chk("mem_valid", {31'd0, mem_read_valid}, 32'd1);
        mem_read = 1'b0;
    endtask

    task automatic mem_rw(input logic [7:0] a, input logic [31:0] d, input logic [31:0] e);
        mem_read = 1'b1; mem_write = 1'b1; mem_address = a; mem_data_in = d;
        mem_exp_q.push_back(e);
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        reg_read = 1'b0; reg_write = 1'b0; reg_address = 2'd0; reg_data_in = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = 8'd0; mem_data_in = 32'd0;
        repeat (3) tick();
        chk("rst_reg_valid", {31'd0, reg_read_valid}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("rst_reg_data",  reg_data_out, 32'd0);
        chk("rst_mem_data",  mem_data_out, 32'd0);
        chk("rst_irq",       {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick();

        // Memory fill and readback
        for (int k = 0; k < 256; k++) mem_wr(8'(k), 32'(1024 + 4 * k));
        for (int k = 0; k < 256; k++) mem_rd(8'(k), 32'(1024 + 4 * k));
        tick();
        chk("mem_valid_drop", {31'd0, mem_read_valid}, 32'd0);
        chk("mem_data_hold",  mem_data_out, 32'd2044);
        mem_rw(8'd5, 32'hDEAD_BEEF, 32'd1044);
        mem_rd(8'd5, 32'hDEAD_BEEF);

        // Register basics, counter disabled
        reg_wr(2'd0, 32'hABCD_0043);
        reg_rd(2'd0, 32'd67);
        reg_rd(2'd2, 32'd0);
        reg_wr(2'd3, 32'hFFFF_FFFF);
        reg_rd(2'd3, 32'd0);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        tick();
        chk("reg_valid_drop", {31'd0, reg_read_valid}, 32'd0);
        chk("reg_data_hold",  reg_data_out, 32'd0);
        reg_rw(2'd0, 32'd100, 32'd67);
        reg_rd(2'd0, 32'd100);
        reg_wr(2'd0, 32'd67);

        // Count up from 67; config write is edge E0
        reg_wr(2'd1, 32'hFFFF_FFFB);
        reg_rd(2'd1, 32'd3);                 // E0+1
        reg_rd(2'd0, 32'd68);                // E0+2
        repeat (65465) tick();               // through E0+65467
        reg_rd(2'd0, 32'd65534);             // E0+65468
        reg_rd(2'd2, 32'd0);                 // E0+65469, wrap edge
        reg_rd(2'd0, 32'd0);                 // E0+65470
        reg_rd(2'd2, 32'd1);                 // E0+65471
        chk("irq_ie_off", {31'd0, irq}, 32'd0);

        // Interrupt enable and W1C
        reg_wr(2'd1, 32'd7);
        chk("irq_ie_on", {31'd0, irq}, 32'd1);
        reg_wr(2'd2, 32'd1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        reg_rd(2'd2, 32'd0);
        reg_rd(2'd0, 32'd5);                 // E0+65475

        // Count down, wrap through zero
        reg_wr(2'd1, 32'd5);                 // F0
        reg_wr(2'd0, 32'd0);                 // F1
        chk("irq_before_dn_wrap", {31'd0, irq}, 32'd0);
        tick();                              // F2: 0 -> FFFF
        chk("irq_dn_wrap", {31'd0, irq}, 32'd1);
        reg_rd(2'd0, 32'h0000_FFFF);         // F3
        reg_rd(2'd2, 32'd1);                 // F4
        reg_wr(2'd0, 32'd1);                 // F5
        reg_wr(2'd2, 32'd1);                 // F6: 1 -> 0, flag cleared
        chk("irq_clr2", {31'd0, irq}, 32'd0);
        reg_wr(2'd2, 32'd1);                 // F7: wrap coincides with clear
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        reg_rd(2'd2, 32'd1);
        reg_wr(2'd1, 32'd1);
        chk("irq_ie_clear", {31'd0, irq}, 32'd0);
        reg_wr(2'd1, 32'd5);
        chk("irq_ie_reen", {31'd0, irq}, 32'd1);

        // Reset during counting with reads in flight
        reg_read = 1'b1; reg_address = 2'd0;
        mem_read = 1'b1; mem_address = 8'd10;
        tick();
        chk("pend_reg_valid", {31'd0, reg_read_valid}, 32'd1);
        chk("pend_mem_valid", {31'd0, mem_read_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_reg_valid", {31'd0, reg_read_valid}, 32'd0);
        chk("arst_mem_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("arst_reg_data",  reg_data_out, 32'd0);
        chk("arst_mem_data",  mem_data_out, 32'd0);
        chk("arst_irq",       {31'd0, irq}, 32'd0);
        reg_read = 1'b0; mem_read = 1'b0;
        tick();
        reset = 1'b0;
        reg_rd(2'd0, 32'd0);
        reg_rd(2'd1, 32'd0);
        reg_rd(2'd2, 32'd0);
        chk("post_rst_irq", {31'd0, irq}, 32'd0);
        tick();
        reg_rd(2'd0, 32'd0);
        mem_rd(8'd10, 32'd1064);
        tick();

        chk("reg_sb_empty", 32'(reg_exp_q.size()), 32'd0);
        chk("mem_sb_empty", 32'(mem_exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
